// File: rtl/decode_64b_66b_pkg.sv
// -----------------------------------------------------------------------------
// decode_64b_66b_pkg
//   Constants shared by the 64b/66b receive decoder and its lock FSM:
//   sync headers, block type field values, XGMII control characters and a
//   lookup that maps terminate block types to their data-byte count.
// -----------------------------------------------------------------------------
package decode_64b_66b_pkg;

  // Sync headers
  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_CTRL = 2'b01;

  // Block type field (payload [7:0] of a control block)
  localparam logic [7:0] BT_IDLE = 8'h1E;
  localparam logic [7:0] BT_S0   = 8'h78;
  localparam logic [7:0] BT_S4   = 8'h33;
  localparam logic [7:0] BT_T0   = 8'h87;
  localparam logic [7:0] BT_T1   = 8'h99;
  localparam logic [7:0] BT_T2   = 8'hAA;
  localparam logic [7:0] BT_T3   = 8'hB4;
  localparam logic [7:0] BT_T4   = 8'hCC;
  localparam logic [7:0] BT_T5   = 8'hD2;
  localparam logic [7:0] BT_T6   = 8'hE1;
  localparam logic [7:0] BT_T7   = 8'hFF;

  // XGMII control characters
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERR   = 8'hFE;

  typedef struct packed {
    logic       hit;  // block type is one of the eight terminate types
    logic [3:0] k;    // data bytes preceding the terminate character
  } term_info_t;

  function automatic term_info_t term_lookup(input logic [7:0] bt);
    term_info_t t;
    t.hit = 1'b1;
    t.k   = 4'd0;
    case (bt)
      BT_T0:   t.k = 4'd0;
      BT_T1:   t.k = 4'd1;
      BT_T2:   t.k = 4'd2;
      BT_T3:   t.k = 4'd3;
      BT_T4:   t.k = 4'd4;
      BT_T5:   t.k = 4'd5;
      BT_T6:   t.k = 4'd6;
      BT_T7:   t.k = 4'd7;
      default: t.hit = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/decode_64b_66b_block_lock_fsm.sv
// -----------------------------------------------------------------------------
// decode_64b_66b_block_lock_fsm
//   Header-sync block lock: HUNT -> LOCKED after LOCK_CNT consecutive good
//   headers; a bad header in HUNT, or BAD_MAX bad headers inside one
//   LOCK_CNT-beat window while LOCKED, requests a gearbox bitslip and parks in
//   SLIP for SLIP_WAIT valid beats. Only valid beats advance anything.
// Ports
//   clk_i         in  clock
//   rst_i         in  synchronous reset, active-high
//   beat_vld_i    in  header valid this cycle
//   head_i        in  2-bit sync header
//   block_lock_o  out registered, high while in LOCKED
//   bitslip_o     out one-cycle bitslip request
// -----------------------------------------------------------------------------
module decode_64b_66b_block_lock_fsm
  import decode_64b_66b_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       beat_vld_i,
  input  logic [1:0] head_i,
  output logic       block_lock_o,
  output logic       bitslip_o
);

  localparam int SH_W   = (LOCK_CNT  > 1) ? $clog2(LOCK_CNT)  : 1;
  localparam int BAD_W  = $clog2(BAD_MAX + 1);
  localparam int SLIP_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_MAX - 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SLIP   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]        state_reg,    state_next;
  logic [SH_W-1:0]   sh_cnt_reg,   sh_cnt_next;
  logic [BAD_W-1:0]  bad_cnt_reg,  bad_cnt_next;
  logic [SLIP_W-1:0] slip_cnt_reg, slip_cnt_next;
  logic              bitslip_reg,  bitslip_next;
  logic              lock_reg;
  logic              head_ok;

  assign head_ok = (head_i == SH_DATA) || (head_i == SH_CTRL);

  always_comb begin
    state_next    = state_reg;
    sh_cnt_next   = sh_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    slip_cnt_next = slip_cnt_reg;
    bitslip_next  = 1'b0;
    if (beat_vld_i) begin
      case (state_reg)
        ST_HUNT: begin
          if (head_ok) begin
            if (sh_cnt_reg == SH_LAST) begin
              state_next   = ST_LOCKED;
              sh_cnt_next  = '0;
              bad_cnt_next = '0;
            end else begin
              sh_cnt_next = sh_cnt_reg + SH_W'(1);
            end
          end else begin
            bitslip_next  = 1'b1;
            sh_cnt_next   = '0;
            bad_cnt_next  = '0;
            slip_cnt_next = '0;
            state_next    = ST_SLIP;
          end
        end
        ST_SLIP: begin
          // Headers are meaningless while the gearbox settles.
          if (slip_cnt_reg == SLIP_LAST) begin
            slip_cnt_next = '0;
            state_next    = ST_HUNT;
          end else begin
            slip_cnt_next = slip_cnt_reg + SLIP_W'(1);
          end
        end
        ST_LOCKED: begin
          // Loss of lock is tested first so it beats a coincident window wrap.
          if (!head_ok && (bad_cnt_reg == BAD_LAST)) begin
            bitslip_next  = 1'b1;
            sh_cnt_next   = '0;
            bad_cnt_next  = '0;
            slip_cnt_next = '0;
            state_next    = ST_SLIP;
          end else if (sh_cnt_reg == SH_LAST) begin
            sh_cnt_next  = '0;
            bad_cnt_next = '0;
          end else begin
            sh_cnt_next = sh_cnt_reg + SH_W'(1);
            if (!head_ok) begin
              bad_cnt_next = bad_cnt_reg + BAD_W'(1);
            end
          end
        end
        default: state_next = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_HUNT;
      sh_cnt_reg   <= '0;
      bad_cnt_reg  <= '0;
      slip_cnt_reg <= '0;
      bitslip_reg  <= 1'b0;
      lock_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sh_cnt_reg   <= sh_cnt_next;
      bad_cnt_reg  <= bad_cnt_next;
      slip_cnt_reg <= slip_cnt_next;
      bitslip_reg  <= bitslip_next;
      lock_reg     <= (state_next == ST_LOCKED);
    end
  end

  assign block_lock_o = lock_reg;
  assign bitslip_o    = bitslip_reg;

endmodule

// File: rtl/decode_64b_66b.sv
// -----------------------------------------------------------------------------
// decode_64b_66b
//   Receive 64b/66b decoder: 66-bit blocks from the GTX gearbox in, XGMII
//   rxd/rxc out with one clock of latency. Lane 0 is rxd[7:0]; the block type
//   field is payload [7:0]. Block lock comes from the lock FSM sub-module.
//   Optional build macro DECODE_ERR_CNT_EN adds a saturating 16-bit count of
//   output beats flagged with decode_error_o.
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   decode_data_i [63:0]  payload from GTX
//   decode_head_i [1:0]   sync header from GTX
//   decode_data_vld_i     payload/header valid
//   xgmii_rxd_o   [63:0]  decoded data
//   xgmii_rxc_o   [7:0]   decoded control, bit n = lane n
//   xgmii_rxd_vld_o       output valid (input valid delayed one clock)
//   decode_error_o        bad header / unknown type on this beat (locked only)
//   block_lock_o          block lock achieved
//   bitslip_o             one-cycle bitslip request to GTX
//   err_cnt_o     [15:0]  only with DECODE_ERR_CNT_EN
// -----------------------------------------------------------------------------
module decode_64b_66b
  import decode_64b_66b_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] decode_data_i,
  input  logic [1:0]  decode_head_i,
  input  logic        decode_data_vld_i,
  output logic [63:0] xgmii_rxd_o,
  output logic [7:0]  xgmii_rxc_o,
  output logic        xgmii_rxd_vld_o,
  output logic        decode_error_o,
  output logic        block_lock_o,
  output logic        bitslip_o
`ifdef DECODE_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);

  logic [63:0] rxd_reg, rxd_next;
  logic [7:0]  rxc_reg, rxc_next;
  logic        vld_reg;
  logic        err_reg, err_next;
  logic        locked;
  logic [63:0] term_rxd;
  term_info_t  term;

  decode_64b_66b_block_lock_fsm #(
    .LOCK_CNT  (LOCK_CNT),
    .BAD_MAX   (BAD_MAX),
    .SLIP_WAIT (SLIP_WAIT)
  ) u_lock_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .beat_vld_i   (decode_data_vld_i),
    .head_i       (decode_head_i),
    .block_lock_o (locked),
    .bitslip_o    (bitslip_o)
  );

  assign term = term_lookup(decode_data_i[7:0]);

  // Terminate blocks: lanes below k carry payload bytes starting at
  // data[15:8], lane k carries /T/, lanes above are idle.
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_term_lane
    if (gi < 7) begin : g_low
      assign term_rxd[8*gi +: 8] = (4'(gi) < term.k)  ? decode_data_i[8*gi+8 +: 8] :
                                   (4'(gi) == term.k) ? XG_TERM : XG_IDLE;
    end else begin : g_top
      assign term_rxd[8*gi +: 8] = (term.k == 4'd7) ? XG_TERM : XG_IDLE;
    end
  end

  // The lock state used here is the one before this edge's update, so the
  // beat that loses lock is still decoded (and flagged) as a locked beat.
  always_comb begin
    rxd_next = {8{XG_ERR}};
    rxc_next = 8'hFF;
    err_next = 1'b0;
    if (locked) begin
      if (decode_head_i == SH_DATA) begin
        rxd_next = decode_data_i;
        rxc_next = 8'h00;
      end else if (decode_head_i == SH_CTRL) begin
        if (term.hit) begin
          rxd_next = term_rxd;
          rxc_next = 8'hFF << term.k;
        end else begin
          case (decode_data_i[7:0])
            BT_IDLE: rxd_next = {8{XG_IDLE}};
            BT_S0: begin
              rxd_next = {decode_data_i[63:8], XG_START};
              rxc_next = 8'h01;
            end
            BT_S4: begin
              rxd_next = {decode_data_i[63:40], XG_START, {4{XG_IDLE}}};
              rxc_next = 8'h1F;
            end
            default: err_next = 1'b1;
          endcase
        end
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_reg <= {8{XG_IDLE}};
      rxc_reg <= 8'hFF;
      vld_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      vld_reg <= decode_data_vld_i;
      if (decode_data_vld_i) begin
        rxd_reg <= rxd_next;
        rxc_reg <= rxc_next;
        err_reg <= err_next;
      end
    end
  end

`ifdef DECODE_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_reg <= '0;
    end else if (decode_data_vld_i && err_next && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_reg;
`endif

  assign xgmii_rxd_o     = rxd_reg;
  assign xgmii_rxc_o     = rxc_reg;
  assign xgmii_rxd_vld_o = vld_reg;
  assign decode_error_o  = err_reg;
  assign block_lock_o    = locked;

endmodule

// File: tb/tb_decode_64b_66b.sv
// -----------------------------------------------------------------------------
// tb_decode_64b_66b
//   Directed vectors with hand-computed expectations for decode_64b_66b.
//   Build with DECODE_ERR_CNT_EN defined to also cover err_cnt_o.
// -----------------------------------------------------------------------------
module tb_decode_64b_66b;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] decode_data_i;
  logic [1:0]  decode_head_i;
  logic        decode_data_vld_i;
  logic [63:0] xgmii_rxd_o;
  logic [7:0]  xgmii_rxc_o;
  logic        xgmii_rxd_vld_o;
  logic        decode_error_o;
  logic        block_lock_o;
  logic        bitslip_o;
`ifdef DECODE_ERR_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  localparam logic [63:0] ALL_IDLE = 64'h0707070707070707;
  localparam logic [63:0] ALL_ERR  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] IDLE_BLK = 64'h000000000000001E;

  int n_checks = 0;
  int n_fail   = 0;
  int n_beat   = 0;

  decode_64b_66b dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .decode_data_i     (decode_data_i),
    .decode_head_i     (decode_head_i),
    .decode_data_vld_i (decode_data_vld_i),
    .xgmii_rxd_o       (xgmii_rxd_o),
    .xgmii_rxc_o       (xgmii_rxc_o),
    .xgmii_rxd_vld_o   (xgmii_rxd_vld_o),
    .decode_error_o    (decode_error_o),
    .block_lock_o      (block_lock_o),
    .bitslip_o         (bitslip_o)
`ifdef DECODE_ERR_CNT_EN
    ,
    .err_cnt_o         (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One valid beat; returns 1 time unit after the edge that produced its output.
  task automatic beat(input logic [1:0] h, input logic [63:0] d);
    decode_head_i     = h;
    decode_data_i     = d;
    decode_data_vld_i = 1'b1;
    @(posedge clk_i);
    #1;
    decode_data_vld_i = 1'b0;
    n_beat++;
    $display("beat %0d head=%b data=%h -> rxd=%h rxc=%h err=%b lock=%b slip=%b",
             n_beat, h, d, xgmii_rxd_o, xgmii_rxc_o, decode_error_o, block_lock_o, bitslip_o);
  endtask

  task automatic gap();
    decode_data_vld_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) beat(2'b01, IDLE_BLK);
  endtask

  initial begin
    rst_i             = 1'b1;
    decode_data_i     = '0;
    decode_head_i     = 2'b00;
    decode_data_vld_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_rxd",  xgmii_rxd_o,     ALL_IDLE);
    check("rst_rxc",  64'(xgmii_rxc_o), 64'hFF);
    check("rst_vld",  64'(xgmii_rxd_vld_o), 64'h0);
    check("rst_err",  64'(decode_error_o), 64'h0);
    check("rst_lock", 64'(block_lock_o), 64'h0);
    check("rst_slip", 64'(bitslip_o), 64'h0);
    rst_i = 1'b0;

    // Bad header while hunting: bitslip pulse, unlocked output is FE with no error.
    beat(2'b00, 64'h0);
    check("hunt_bad_slip", 64'(bitslip_o), 64'h1);
    check("unlk_rxd",      xgmii_rxd_o, ALL_ERR);
    check("unlk_rxc",      64'(xgmii_rxc_o), 64'hFF);
    check("unlk_err",      64'(decode_error_o), 64'h0);
    gap();
    check("slip_pulse_end", 64'(bitslip_o), 64'h0);
    check("gap_vld",        64'(xgmii_rxd_vld_o), 64'h0);

    // 32 ignored beats, then 64 good headers to lock.
    idles(32 + 63);
    check("no_lock_95", 64'(block_lock_o), 64'h0);
    idles(1);
    check("lock_96", 64'(block_lock_o), 64'h1);

    // Window beat 1: idle
    idles(1);
    check("idle_rxd", xgmii_rxd_o, ALL_IDLE);
    check("idle_rxc", 64'(xgmii_rxc_o), 64'hFF);
    check("idle_err", 64'(decode_error_o), 64'h0);
    check("idle_vld", 64'(xgmii_rxd_vld_o), 64'h1);
    // 2: start in lane 0
    beat(2'b01, 64'hDDCCBBAA99887778);
    check("s0_rxd", xgmii_rxd_o, 64'hDDCCBBAA998877FB);
    check("s0_rxc", 64'(xgmii_rxc_o), 64'h01);
    // 3: data, then a gap that must hold outputs
    beat(2'b10, 64'h1122334455667788);
    check("data_rxd", xgmii_rxd_o, 64'h1122334455667788);
    check("data_rxc", 64'(xgmii_rxc_o), 64'h00);
    gap();
    gap();
    check("hold_vld", 64'(xgmii_rxd_vld_o), 64'h0);
    check("hold_rxd", xgmii_rxd_o, 64'h1122334455667788);
    check("hold_rxc", 64'(xgmii_rxc_o), 64'h00);
    // 4: terminate with no data bytes
    beat(2'b01, 64'h0000000000000087);
    check("t0_rxd", xgmii_rxd_o, 64'h07070707070707FD);
    check("t0_rxc", 64'(xgmii_rxc_o), 64'hFF);
    // 5: terminate after 3 bytes
    beat(2'b01, 64'h00000000CCBBAAB4);
    check("t3_rxd", xgmii_rxd_o, 64'h07070707FDCCBBAA);
    check("t3_rxc", 64'(xgmii_rxc_o), 64'hF8);
    // 6: start in lane 4
    beat(2'b01, 64'h6655440000000033);
    check("s4_rxd", xgmii_rxd_o, 64'h665544FB07070707);
    check("s4_rxc", 64'(xgmii_rxc_o), 64'h1F);
    // 7: terminate after 7 bytes
    beat(2'b01, 64'h77665544332211FF);
    check("t7_rxd", xgmii_rxd_o, 64'hFD77665544332211);
    check("t7_rxc", 64'(xgmii_rxc_o), 64'h80);
    // 8: unknown block type
    beat(2'b01, 64'h0000000000000055);
    check("bt55_rxd", xgmii_rxd_o, ALL_ERR);
    check("bt55_rxc", 64'(xgmii_rxc_o), 64'hFF);
    check("bt55_err", 64'(decode_error_o), 64'h1);
`ifdef DECODE_ERR_CNT_EN
    check("errcnt_1", 64'(err_cnt_o), 64'd1);
`endif
    // 9: invalid header 11 while locked
    beat(2'b11, 64'h0);
    check("sh11_err",  64'(decode_error_o), 64'h1);
    check("sh11_lock", 64'(block_lock_o), 64'h1);
`ifdef DECODE_ERR_CNT_EN
    check("errcnt_2", 64'(err_cnt_o), 64'd2);
`endif
    // Finish this window so the bad count restarts cleanly.
    idles(55);

    // Window A: 15 bad headers -> lock held across the wrap.
    for (int i = 0; i < 15; i++) beat(2'b00, 64'h0);
    check("win15_mid_lock", 64'(block_lock_o), 64'h1);
    idles(49);
    check("win15_end_lock", 64'(block_lock_o), 64'h1);

    // Window B: 16th bad header lands on the wrap beat; loss of lock wins.
    idles(48);
    for (int i = 0; i < 15; i++) beat(2'b00, 64'h0);
    check("win16_pre_lock", 64'(block_lock_o), 64'h1);
    check("win16_pre_slip", 64'(bitslip_o), 64'h0);
    beat(2'b00, 64'h0);
    check("win16_lock", 64'(block_lock_o), 64'h0);
    check("win16_slip", 64'(bitslip_o), 64'h1);
    check("win16_err",  64'(decode_error_o), 64'h1);
    check("win16_rxd",  xgmii_rxd_o, ALL_ERR);
    gap();
    check("win16_slip_end", 64'(bitslip_o), 64'h0);

    // Re-acquire lock, then reset in the middle of a frame.
    idles(32 + 64);
    check("relock", 64'(block_lock_o), 64'h1);
    beat(2'b01, 64'hDDCCBBAA99887778);
    check("relock_s0_rxc", 64'(xgmii_rxc_o), 64'h01);
    rst_i             = 1'b1;
    decode_head_i     = 2'b10;
    decode_data_i     = 64'hA5A5A5A5A5A5A5A5;
    decode_data_vld_i = 1'b1;
    @(posedge clk_i);
    #1;
    decode_data_vld_i = 1'b0;
    rst_i             = 1'b0;
    check("midrst_rxd",  xgmii_rxd_o, ALL_IDLE);
    check("midrst_rxc",  64'(xgmii_rxc_o), 64'hFF);
    check("midrst_vld",  64'(xgmii_rxd_vld_o), 64'h0);
    check("midrst_lock", 64'(block_lock_o), 64'h0);
    check("midrst_err",  64'(decode_error_o), 64'h0);
`ifdef DECODE_ERR_CNT_EN
    check("midrst_errcnt", 64'(err_cnt_o), 64'd0);
`endif
    beat(2'b10, 64'h1122334455667788);
    check("postrst_unlk_rxd", xgmii_rxd_o, ALL_ERR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
